fetch_fifo: RTL and testbench

FETCH_FIFO -- requirements
Module: fetch_fifo

---
 rtl/ariane_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 76 +++++++
 tb/tb_fetch_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared front-end types: the fetch_entry record handed from fetch to decode
// and the default instruction-queue depth used at the top level.
package ariane_pkg;

   localparam int unsigned FETCH_FIFO_DEPTH = 4;
   localparam int unsigned VLEN             = 64;

   typedef enum logic [2:0] {
      NO_CF  = 3'd0,
      BRANCH = 3'd1,
      JUMP   = 3'd2,
      JUMPR  = 3'd3,
      RETURN = 3'd4
   } cf_t;

   typedef struct packed {
      cf_t             cf;
      logic [VLEN-1:0] predict_address;
   } branchpredict_sbe_t;

   typedef struct packed {
      logic [VLEN-1:0]    address;
      logic [31:0]        instruction;
      branchpredict_sbe_t branch_predict;
      logic               is_compressed;
      logic               is_illegal;
   } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between fetch and decode: DEPTH-slot circular buffer of
// fetch_entry records. Define FETCH_FIFO_BYPASS_EN for a zero-latency empty-queue bypass.
module fetch_fifo
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      in_valid_i,
   input  fetch_entry                in_entry_i,
   output logic                      in_ready_o,
   output logic                      out_valid_o,
   output fetch_entry                out_entry_o,
   input  logic                      out_ready_i,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry         mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [CNT_W-1:0]   count_q;

   logic               not_empty;
   logic               bypass;
   logic               push;
   logic               pop;

   assign not_empty  = (count_q != '0);
   assign in_ready_o = (count_q != FULL_CNT);
   assign count_o    = count_q;

   always_comb begin
      bypass      = 1'b0;
      out_valid_o = not_empty;
      out_entry_o = not_empty ? mem[rd_ptr_q] : '0;
`ifdef FETCH_FIFO_BYPASS_EN
      if (!not_empty && in_valid_i && !flush_i) begin
         bypass      = 1'b1;
         out_valid_o = 1'b1;
         out_entry_o = in_entry_i;
      end
`endif
   end

   // A bypassed entry consumed in the same cycle never lands in storage.
   assign push = in_valid_i && in_ready_o && !(bypass && out_ready_i);
   assign pop  = not_empty && out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; occupancy is tracked solely by the counter.
   always_ff @(posedge clk_i) begin
      if (push && !rst_i && !flush_i) mem[wr_ptr_q] <= in_entry_i;
   end

endmodule

// File: tb/tb_fetch_fifo.sv
// Directed, table-driven self-checking bench for fetch_fifo (DEPTH=4).
module tb_fetch_fifo;
   import ariane_pkg::*;

`ifdef FETCH_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       flush_i = 1'b0;
   logic       in_valid_i = 1'b0;
   fetch_entry in_entry_i = '0;
   logic       in_ready_o;
   logic       out_valid_o;
   fetch_entry out_entry_o;
   logic       out_ready_i = 1'b0;
   logic [2:0] count_o;

   int checks = 0;
   int failures = 0;

   fetch_fifo #(.DEPTH(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .in_valid_i (in_valid_i),
      .in_entry_i (in_entry_i),
      .in_ready_o (in_ready_o),
      .out_valid_o(out_valid_o),
      .out_entry_o(out_entry_o),
      .out_ready_i(out_ready_i),
      .count_o    (count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        in_valid;
      logic [63:0] in_addr;
      logic        out_ready;
      logic [2:0]  exp_count;
      logic        exp_out_valid;
      logic        exp_in_ready;
      logic [63:0] exp_out_addr;
   } vec_t;

   function automatic fetch_entry mk_entry(input logic [63:0] addr);
      fetch_entry e;
      e = '0;
      e.address                        = addr;
      e.instruction                    = addr[31:0] ^ 32'h1234_0013;
      e.branch_predict.cf              = (addr[3] ? BRANCH : NO_CF);
      e.branch_predict.predict_address = addr + 64'h40;
      e.is_compressed                  = addr[2];
      e.is_illegal                     = addr[4];
      return e;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic f, input logic v, input logic [63:0] a, input logic r);
      @(negedge clk);
      flush_i     = f;
      in_valid_i  = v;
      in_entry_i  = mk_entry(a);
      out_ready_i = r;
      #1;
   endtask

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{0, 0, 64'h00, 0, 3'd0, 0,   1, 64'h00};
      vecs[1]  = '{0, 1, 64'h80, 0, 3'd0, BYP, 1, (BYP ? 64'h80 : 64'h00)};
      vecs[2]  = '{0, 1, 64'h84, 0, 3'd1, 1,   1, 64'h80};
      vecs[3]  = '{0, 1, 64'h88, 0, 3'd2, 1,   1, 64'h80};
      vecs[4]  = '{0, 0, 64'h00, 0, 3'd3, 1,   1, 64'h80};
      vecs[5]  = '{0, 1, 64'h8C, 0, 3'd3, 1,   1, 64'h80};
      vecs[6]  = '{0, 1, 64'h90, 1, 3'd4, 1,   0, 64'h80};
      vecs[7]  = '{0, 0, 64'h00, 0, 3'd3, 1,   1, 64'h84};
      vecs[8]  = '{0, 0, 64'h00, 1, 3'd3, 1,   1, 64'h84};
      vecs[9]  = '{0, 0, 64'h00, 1, 3'd2, 1,   1, 64'h88};
      vecs[10] = '{0, 0, 64'h00, 1, 3'd1, 1,   1, 64'h8C};
      vecs[11] = '{0, 0, 64'h00, 0, 3'd0, 0,   1, 64'h00};

      // Reset state
      drive(0, 0, 64'h0, 0);
      drive(0, 0, 64'h0, 0);
      check("rst_count", count_o, 0);
      check("rst_in_ready", in_ready_o, 1);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_out_entry", out_entry_o, 0);
      @(negedge clk);
      rst_i = 1'b0;

      // Table: fill, hold head stable, full rejection, drain
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_addr, vecs[i].out_ready);
         check($sformatf("vec%0d_count", i), count_o, vecs[i].exp_count);
         check($sformatf("vec%0d_out_valid", i), out_valid_o, vecs[i].exp_out_valid);
         check($sformatf("vec%0d_in_ready", i), in_ready_o, vecs[i].exp_in_ready);
         check($sformatf("vec%0d_out_addr", i), out_entry_o.address, vecs[i].exp_out_addr);
      end
      check("empty_entry_zero", out_entry_o, 0);

      // Streaming: 20 entries, one push and one pop per cycle after the first
      drive(0, 1, 64'h100, 0);
      for (int n = 1; n < 20; n++) begin
         drive(0, 1, 64'h100 + 64'(4 * n), 1);
         check($sformatf("stream%0d_count", n), count_o, 1);
         check($sformatf("stream%0d_entry", n), out_entry_o, mk_entry(64'h100 + 64'(4 * (n - 1))));
      end
      drive(0, 0, 64'h0, 1);
      check("stream_last_entry", out_entry_o, mk_entry(64'h100 + 64'd76));
      drive(0, 0, 64'h0, 0);
      check("stream_drained", count_o, 0);

      // Flush with simultaneous push and pop
      drive(0, 1, 64'h300, 0);
      drive(0, 1, 64'h304, 0);
      drive(0, 1, 64'h308, 0);
      drive(1, 1, 64'h30C, 1);
      check("pre_flush_count", count_o, 3);
      drive(0, 0, 64'h0, 0);
      check("flush_count", count_o, 0);
      check("flush_out_valid", out_valid_o, 0);
      check("flush_out_entry", out_entry_o, 0);
      drive(0, 0, 64'h0, 0);
      check("flush_nothing_stored", count_o, 0);

      // Reset mid-operation with a simultaneous push offered
      drive(0, 1, 64'h400, 0);
      drive(0, 1, 64'h404, 0);
      @(negedge clk);
      rst_i = 1'b1;
      in_valid_i = 1'b1;
      in_entry_i = mk_entry(64'h408);
      #1;
      check("pre_rst_count", count_o, 2);
      drive(0, 0, 64'h0, 0);
      rst_i = 1'b0;
      check("midrst_count", count_o, 0);
      check("midrst_in_ready", in_ready_o, 1);
      check("midrst_out_valid", out_valid_o, 0);
      check("midrst_out_entry", out_entry_o, 0);

      // Push into empty queue with decode ready
      drive(0, 1, 64'h200, 1);
      check("empty_push_out_valid", out_valid_o, BYP);
      check("empty_push_count", count_o, 0);
      if (BYP) check("bypass_addr", out_entry_o.address, 64'h200);
      drive(0, 0, 64'h0, 1);
      check("after_push_count", count_o, BYP ? 0 : 1);
      check("after_push_out_valid", out_valid_o, !BYP);
      check("after_push_addr", out_entry_o.address, BYP ? 64'h0 : 64'h200);
      drive(0, 0, 64'h0, 0);
      check("after_pop_count", count_o, 0);

      // Flush suppresses any bypass and stores nothing
      drive(1, 1, 64'h500, 1);
      check("flush_bypass_out_valid", out_valid_o, 0);
      drive(0, 0, 64'h0, 0);
      check("flush_bypass_count", count_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
